lcd_bus_sequencer: RTL

Byte-level HD44780 bus engine that sits between the character-formatting LCD driver and the physical 2x16 display pins. After power-up it runs the controller init sequence on its own. It then accepts one command or data byte at a time over a valid/ready handshake and drives RS/RW/E/DB with real setup, pulse-width, hold and execution-time spacing, all derived from counters. This replaces per-clock E toggling and makes the display interface clock-rate independent.

---
 rtl/lcd_pkg.sv | 24 ++
 rtl/lcd_delay_counter.sv | 27 ++
 rtl/lcd_bus_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared HD44780 definitions: command bytes and the bus sequencer state encoding.
// Also consumed by the upstream character-formatting LCD driver.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] LCD_DISP_ON       = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC     = 8'h06;
  localparam logic [7:0] LCD_CLEAR         = 8'h01;
  localparam logic [7:0] LCD_HOME          = 8'h02;
  localparam logic [7:0] LCD_LINE0         = 8'h80;
  localparam logic [7:0] LCD_LINE1         = 8'hC0;

  localparam logic [2:0] INIT_LAST = 3'd5;

  typedef enum logic [2:0] {
    PWRUP,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } state_t;

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter that paces every bus phase; it parks at zero until reloaded.
module lcd_delay_counter #(
  parameter int             CW        = 20,
  parameter logic [CW-1:0]  RST_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          zero
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_VALUE;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// HD44780 byte engine: runs the controller init on its own, then writes one handshaked
// byte at a time with counter-timed setup, E pulse, hold and execution wait.
module lcd_bus_sequencer
  import lcd_pkg::*;
#(
  parameter int T_SETUP = 3,
  parameter int T_PULSE = 12,
  parameter int T_HOLD  = 2,
  parameter int T_EXEC  = 2000,
  parameter int T_LONG  = 82000,
  parameter int T_PWRUP = 800000,
  parameter int CW      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       init_done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  // Counters load N-1 on state entry so each phase lasts exactly N cycles.
  localparam logic [CW-1:0] SETUP_LD = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] EXEC_LD  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(T_LONG - 1);
  localparam logic [CW-1:0] PWRUP_LD = CW'(T_PWRUP - 1);

  state_t      state_q, state_d;
  logic [2:0]  initIdx_q, initIdx_d;
  logic        initDone_q, initDone_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic [7:0]  romByte;
  logic        longCmd;
  logic        cntLoad, cntZero;
  logic [CW-1:0] cntValue;

  lcd_delay_counter #(
    .CW       (CW),
    .RST_VALUE(PWRUP_LD)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .load (cntLoad),
    .value(cntValue),
    .zero (cntZero)
  );

  always_comb begin
    case (initIdx_q)
      3'd0, 3'd1, 3'd2: romByte = LCD_FUNC_SET_8B2L;
      3'd3:             romByte = LCD_DISP_ON;
      3'd4:             romByte = LCD_ENTRY_INC;
      default:          romByte = LCD_CLEAR;
    endcase
  end

  // Clear (0x01), home (0x02) and its don't-care alias 0x03 need the long execution time.
  assign longCmd = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

  always_comb begin
    state_d    = state_q;
    initIdx_d  = initIdx_q;
    initDone_d = initDone_q;
    data_d     = data_q;
    rs_d       = rs_q;
    cntLoad    = 1'b0;
    cntValue   = SETUP_LD;
    case (state_q)
      PWRUP: begin
        if (cntZero) begin
          data_d  = romByte;
          rs_d    = 1'b0;
          cntLoad = 1'b1;
          state_d = SETUP;
        end
      end
      IDLE: begin
        if (!initDone_q) begin
          data_d  = romByte;
          rs_d    = 1'b0;
          cntLoad = 1'b1;
          state_d = SETUP;
        end else if (in_valid && in_ready) begin
          data_d  = in_data;
          rs_d    = in_rs;
          cntLoad = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cntZero) begin
          cntLoad  = 1'b1;
          cntValue = PULSE_LD;
          state_d  = PULSE;
        end
      end
      PULSE: begin
        if (cntZero) begin
          cntLoad  = 1'b1;
          cntValue = HOLD_LD;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (cntZero) begin
          cntLoad  = 1'b1;
          cntValue = longCmd ? LONG_LD : EXEC_LD;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cntZero) begin
          if (!initDone_q) begin
            if (initIdx_q == INIT_LAST) begin
              initDone_d = 1'b1;
            end else begin
              initIdx_d = initIdx_q + 3'd1;
            end
          end
          state_d = IDLE;
        end
      end
      default: state_d = PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PWRUP;
      initIdx_q  <= '0;
      initDone_q <= 1'b0;
      data_q     <= '0;
      rs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      initIdx_q  <= initIdx_d;
      initDone_q <= initDone_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
    end
  end

  assign lcd_en    = (state_q == PULSE);
  assign in_ready  = (state_q == IDLE) && initDone_q;
  assign init_done = initDone_q;
  assign lcd_data  = data_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;

endmodule
